// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) arithmetic and S-box helpers for the SubBytes pipeline.
// The 256-entry tables are reference data for benches; the datapath never reads them.
package aes_pkg;

    localparam logic [7:0] GF_POLY      = 8'h1B;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] AFFINE_INV_C = 8'h05;

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

    // x^254 by repeated squaring; zero maps to zero without a special case.
    function automatic logic [7:0] gf_inv8(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ AFFINE_INV_C;
    endfunction

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// One-byte combinational AES S-box, forward or inverse, built from GF(2^8) logic.
// Both directions share a single field inverter; only the affine step moves around it.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);

    logic [7:0] g;

    always_comb begin
        g = gf_inv8(inv ? affine_inv(x) : x);
        y = inv ? g : affine_fwd(g);
    end

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane pipelined AES SubBytes with per-beat forward/inverse mode.
// Handshake: a beat moves on a side exactly when valid && ready is high at the rising edge.
module aes_subbytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter bit INV_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inv,
    output logic [8*LANES-1:0]   out_data
);

    localparam int W        = 8 * LANES;
    localparam int LAST     = PIPE_STAGES - 1;
    // Single-stage builds substitute before the only register; otherwise after stage 0.
    localparam int SB_STAGE = (PIPE_STAGES == 1) ? 0 : 1;

    logic [PIPE_STAGES-1:0]        valid_q, valid_d;
    logic [PIPE_STAGES-1:0]        inv_q, inv_d;
    logic [PIPE_STAGES-1:0][W-1:0] data_q, data_d;
    logic [PIPE_STAGES-1:0]        adv;
    logic                          mode_in;
    logic [W-1:0]                  sb_x, sb_y;
    logic                          sb_inv;

    assign mode_in = INV_EN ? in_inv : 1'b0;

    if (PIPE_STAGES == 1) begin : g_sb_at_input
        assign sb_x   = in_data;
        assign sb_inv = mode_in;
    end else begin : g_sb_after_stage0
        assign sb_x   = data_q[0];
        assign sb_inv = inv_q[0];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_lane u_lane (
            .x   (sb_x[8*l +: 8]),
            .inv (sb_inv),
            .y   (sb_y[8*l +: 8])
        );
    end

    // Stages beyond SB_STAGE only delay the result so retiming can spread the inverter.
    always_comb begin
        adv[LAST] = !valid_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end

        valid_d = valid_q;
        inv_d   = inv_q;
        data_d  = data_q;

        if (adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                inv_d[0]  = mode_in;
                data_d[0] = (SB_STAGE == 0) ? sb_y : in_data;
            end
        end

        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    inv_d[k]  = inv_q[k-1];
                    data_d[k] = (k == SB_STAGE) ? sb_y : data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            inv_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[LAST];
    assign out_inv   = inv_q[LAST];
    assign out_data  = data_q[LAST];

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Directed bench for aes_subbytes_pipe: main 4-lane/2-stage build plus forward-only
// 4-lane and forward-only 16-lane single-stage builds.
module tb_aes_subbytes_pipe;
    import aes_pkg::*;

    localparam int TR_N = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main build: LANES=4, PIPE_STAGES=2, INV_EN=1
    logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [31:0] in_data, out_data;
    // forward-only build: LANES=4, PIPE_STAGES=2, INV_EN=0
    logic        ni_in_valid, ni_in_ready, ni_in_inv, ni_out_valid, ni_out_ready, ni_out_inv;
    logic [31:0] ni_in_data, ni_out_data;
    // wide single-stage build: LANES=16, PIPE_STAGES=1, INV_EN=0
    logic         w_in_valid, w_in_ready, w_in_inv, w_out_valid, w_out_ready, w_out_inv;
    logic [127:0] w_in_data, w_out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] src_data[$];
    logic        src_inv[$];
    logic [31:0] got_data[$];
    logic        got_inv[$];
    logic        tr_out_valid [TR_N];
    logic        tr_in_ready  [TR_N];
    logic [31:0] tr_out_data  [TR_N];

    aes_subbytes_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
        .out_data(out_data)
    );

    aes_subbytes_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1'b0)) dut_ni (
        .clk(clk), .rst_n(rst_n), .in_valid(ni_in_valid), .in_ready(ni_in_ready), .in_inv(ni_in_inv),
        .in_data(ni_in_data), .out_valid(ni_out_valid), .out_ready(ni_out_ready), .out_inv(ni_out_inv),
        .out_data(ni_out_data)
    );

    aes_subbytes_pipe #(.LANES(16), .PIPE_STAGES(1), .INV_EN(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inv(w_in_inv),
        .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inv(w_out_inv),
        .out_data(w_out_data)
    );

    function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            r[8*l +: 8] = inv ? SBOX_INV[d[8*l +: 8]] : SBOX_FWD[d[8*l +: 8]];
        end
        return r;
    endfunction

    // Streams src_* into the main build, out_ready low for cycles stall_lo..stall_hi.
    task automatic run_stream(input int stall_lo, input int stall_hi, input int max_cycles,
                              output int cycles);
        int idx;
        int n;
        idx    = 0;
        n      = src_data.size();
        cycles = 0;
        got_data.delete();
        got_inv.delete();
        while (got_data.size() < n && cycles < max_cycles) begin
            if (idx < n) begin
                in_valid = 1'b1;
                in_data  = src_data[idx];
                in_inv   = src_inv[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 'x;
                in_inv   = 1'b0;
            end
            out_ready = !(cycles >= stall_lo && cycles <= stall_hi);
            #1;
            if (cycles < TR_N) begin
                tr_out_valid[cycles] = out_valid;
                tr_in_ready[cycles]  = in_ready;
                tr_out_data[cycles]  = out_data;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_inv.push_back(out_inv);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: valid=%b data=%h inv=%b, want 0/00000000/0", out_valid, out_data, out_inv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b data=%h inv=%b, want 0/00000000/0", out_valid, out_data, out_inv);
        end
        tests_run++;
        if (ni_out_valid !== 1'b0 || w_out_valid !== 1'b0 || w_out_data !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_other_builds: ni_valid=%b w_valid=%b w_data=%h, want 0/0/0", ni_out_valid, w_out_valid, w_out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input logic [31:0] din, input logic inv, input logic [31:0] want);
        in_valid  = 1'b1;
        in_inv    = inv;
        in_data   = din;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early_valid: got %b want 0 after 1 cycle", out_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== want || out_inv !== inv) begin
            tests_failed++;
            $display("FAIL single_result: valid=%b data=%h inv=%b, want 1/%h/%b", out_valid, out_data, out_inv, want, inv);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_alternate_modes();
        logic [31:0] vec [8] = '{32'h53_01_00_FF, 32'hED_7C_63_16, 32'h00_11_22_33, 32'h44_55_66_77,
                                 32'h88_99_AA_BB, 32'hCC_DD_EE_FF, 32'h01_23_45_67, 32'h89_AB_CD_EF};
        int cycles;
        src_data.delete();
        src_inv.delete();
        for (int i = 0; i < 8; i++) begin
            src_data.push_back(vec[i]);
            src_inv.push_back(i[0]);
        end
        run_stream(-1, -1, 40, cycles);
        tests_run++;
        if (cycles !== 10 || got_data.size() !== 8) begin
            tests_failed++;
            $display("FAIL alternate_throughput: cycles=%0d beats=%0d, want 10/8", cycles, got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            tests_run++;
            if (got_data[i] !== model_sub({96'h0, vec[i]}, i[0], 4) || got_inv[i] !== i[0]) begin
                tests_failed++;
                $display("FAIL alternate_beat%0d: data=%h inv=%b, want %h/%b", i, got_data[i], got_inv[i],
                         model_sub({96'h0, vec[i]}, i[0], 4), i[0]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [31:0] base [256];
        logic [31:0] fwd_out [256];
        int cycles;
        int n;
        for (int x = 0; x < 256; x++) begin
            for (int j = 0; j < 4; j++) base[x][8*j +: 8] = 8'((x + 67 * j) & 255);
        end
        for (int pass = 0; pass < 3; pass++) begin
            src_data.delete();
            src_inv.delete();
            for (int x = 0; x < 256; x++) begin
                src_data.push_back(pass == 2 ? fwd_out[x] : base[x]);
                src_inv.push_back(pass != 0);
            end
            run_stream(-1, -1, 400, cycles);
            tests_run++;
            if (cycles !== 258 || got_data.size() !== 256) begin
                tests_failed++;
                $display("FAIL exhaustive_pass%0d_count: cycles=%0d beats=%0d, want 258/256", pass, cycles, got_data.size());
            end
            n = got_data.size();
            for (int x = 0; x < n && x < 256; x++) begin
                logic [31:0] want;
                want = (pass == 2) ? base[x] : model_sub({96'h0, base[x]}, pass == 1, 4);
                if (pass == 0) fwd_out[x] = got_data[x];
                tests_run++;
                if (got_data[x] !== want || got_inv[x] !== (pass != 0)) begin
                    tests_failed++;
                    $display("FAIL exhaustive_pass%0d_x%0d: data=%h inv=%b, want %h/%b", pass, x, got_data[x],
                             got_inv[x], want, pass != 0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vec [8] = '{32'h10_20_30_40, 32'h50_60_70_80, 32'h90_A0_B0_C0, 32'hD0_E0_F0_00,
                                 32'h01_02_03_04, 32'h05_06_07_08, 32'hFE_DC_BA_98, 32'h76_54_32_10};
        logic [31:0] held;
        int cycles;
        src_data.delete();
        src_inv.delete();
        for (int i = 0; i < 8; i++) begin
            src_data.push_back(vec[i]);
            src_inv.push_back(1'b0);
        end
        run_stream(3, 7, 60, cycles);
        held = model_sub({96'h0, vec[1]}, 1'b0, 4);
        tests_run++;
        if (cycles !== 15 || got_data.size() !== 8) begin
            tests_failed++;
            $display("FAIL stall_count: cycles=%0d beats=%0d, want 15/8", cycles, got_data.size());
        end
        for (int c = 3; c <= 7; c++) begin
            tests_run++;
            if (tr_in_ready[c] !== 1'b0 || tr_out_valid[c] !== 1'b1 || tr_out_data[c] !== held) begin
                tests_failed++;
                $display("FAIL stall_hold_c%0d: in_ready=%b valid=%b data=%h, want 0/1/%h", c, tr_in_ready[c],
                         tr_out_valid[c], tr_out_data[c], held);
            end
        end
        tests_run++;
        if (tr_in_ready[8] !== 1'b1 || tr_out_valid[8] !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_full: in_ready=%b valid=%b, want 1/1", tr_in_ready[8], tr_out_valid[8]);
        end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            tests_run++;
            if (got_data[i] !== model_sub({96'h0, vec[i]}, 1'b0, 4)) begin
                tests_failed++;
                $display("FAIL stall_order_beat%0d: got %h want %h", i, got_data[i], model_sub({96'h0, vec[i]}, 1'b0, 4));
            end
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = 32'hAA_BB_CC_DD;
        @(posedge clk);
        #1;
        in_data = 32'h11_22_33_44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_setup: valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: valid=%b data=%h inv=%b, want 0/00000000/0", out_valid, out_data, out_inv);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midreset_ghost: out_valid high in %0d cycles, want 0", seen);
        end
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = 32'h00_00_00_00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_next_early: valid=%b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h52_52_52_52 || out_inv !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_next: valid=%b data=%h inv=%b, want 1/52525252/1", out_valid, out_data, out_inv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_inv_disabled();
        ni_out_ready = 1'b1;
        ni_in_valid  = 1'b1;
        ni_in_inv    = 1'b1;
        ni_in_data   = 32'h00_00_00_00;
        @(posedge clk);
        #1;
        ni_in_data = 32'hED_7C_63_16;
        @(posedge clk);
        #1;
        ni_in_valid = 1'b0;
        ni_in_data  = 'x;
        tests_run++;
        if (ni_out_valid !== 1'b1 || ni_out_data !== 32'h63_63_63_63 || ni_out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL noinv_zero: valid=%b data=%h inv=%b, want 1/63636363/0", ni_out_valid, ni_out_data, ni_out_inv);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (ni_out_valid !== 1'b1 || ni_out_data !== 32'h55_10_FB_47 || ni_out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL noinv_fwd: valid=%b data=%h inv=%b, want 1/5510fb47/0", ni_out_valid, ni_out_data, ni_out_inv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wide_single_stage();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_inv    = 1'b1;
        w_in_data   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_pre: valid=%b in_ready=%b, want 0/1", w_out_valid, w_in_ready);
        end
        @(posedge clk);
        #1;
        w_in_data = 128'h0;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_data !== 128'h76abd7fe_2b670130_c56f6bf2_7b777c63 || w_out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_latency1: valid=%b data=%h inv=%b, want 1/76abd7fe2b670130c56f6bf27b777c63/0",
                     w_out_valid, w_out_data, w_out_inv);
        end
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        w_in_data  = 'x;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_data !== {16{8'h63}} || w_out_inv !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_zero: valid=%b data=%h inv=%b, want 1/63..63/0", w_out_valid, w_out_data, w_out_inv);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (w_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_drain: valid=%b want 0", w_out_valid);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_inv       = 1'b0;
        in_data      = 32'h0;
        out_ready    = 1'b1;
        ni_in_valid  = 1'b0;
        ni_in_inv    = 1'b0;
        ni_in_data   = 32'h0;
        ni_out_ready = 1'b1;
        w_in_valid   = 1'b0;
        w_in_inv     = 1'b0;
        w_in_data    = 128'h0;
        w_out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        test_reset();
        test_single(32'h53_01_00_FF, 1'b0, 32'hED_7C_63_16);
        test_single(32'hED_7C_63_16, 1'b1, 32'h53_01_00_FF);
        test_alternate_modes();
        test_exhaustive();
        test_backpressure();
        test_reset_midflight();
        test_inv_disabled();
        test_wide_single_stage();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
